// File: rtl/tensor_core_result_unloader.sv
// Snapshots a tensor-core register file and streams a window of its elements out over valid/ready.
// Define TENSOR_UNLOADER_CHECKSUM_EN to append a modulo-2^DATA_WIDTH sum beat after the data beats.
module tensor_core_result_unloader #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 8,
  localparam int NUM_MATRICES       = (NUMBER_OF_REGISTERS - 1) / 16 + 1,
  localparam int AW                 = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         start_in,
  input  logic [AW-1:0]                first_address_in,
  input  logic [AW:0]                  length_in,
  input  logic signed [DATA_WIDTH-1:0] bulk_read_data_in [NUM_MATRICES][4][4],
  output logic signed [DATA_WIDTH-1:0] stream_data_out,
  output logic                         stream_valid_out,
  input  logic                         stream_ready_in,
  output logic                         stream_last_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [1:0]                   fsm_state
);

  localparam int SW = $clog2(NUM_MATRICES * 16);
  localparam logic [AW:0]   FULL_LEN  = (AW+1)'(NUMBER_OF_REGISTERS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUMBER_OF_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [DATA_WIDTH-1:0] snapshot  [NUM_MATRICES][4][4];
  logic signed [DATA_WIDTH-1:0] snap_flat [NUM_MATRICES*16];
  logic [AW-1:0]                addr;
  logic [AW:0]                  remaining;
  logic [AW:0]                  eff_len;
  logic                         xfer;
  logic                         final_data_beat;
  logic                         final_beat;
  logic signed [DATA_WIDTH-1:0] cur_elem;
  logic signed [DATA_WIDTH-1:0] beat_data;

  // Flat index a lives at [a/16][(a%16)/4][a%4], i.e. plain row-major order.
  for (genvar m = 0; m < NUM_MATRICES; m++) begin : g_mat
    for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
        assign snap_flat[m*16 + r*4 + c] = snapshot[m][r][c];
      end
    end
  end

  assign eff_len = (length_in == '0 || length_in > FULL_LEN) ? FULL_LEN : length_in;
  assign cur_elem = snap_flat[SW'(addr)];
  assign final_data_beat = (remaining == (AW+1)'(1));

  // Handshake: a beat moves on a rising edge with valid and ready both high; once valid
  // rises, data and last stay frozen and valid stays high until that transfer happens.
  assign xfer = stream_valid_out && stream_ready_in;

`ifdef TENSOR_UNLOADER_CHECKSUM_EN
  logic                         csum_phase;
  logic signed [DATA_WIDTH-1:0] csum;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      csum_phase <= 1'b0;
      csum       <= '0;
    end else if (state == IDLE && start_in) begin
      csum_phase <= 1'b0;
      csum       <= '0;
    end else if (xfer && !csum_phase) begin
      csum <= csum + cur_elem;
      if (final_data_beat) csum_phase <= 1'b1;
    end
  end

  assign final_beat = csum_phase;
  assign beat_data  = csum_phase ? csum : cur_elem;
`else
  assign final_beat = final_data_beat;
  assign beat_data  = cur_elem;
`endif

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = STREAM;
      STREAM:  if (xfer && final_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      snapshot  <= '{default: '0};
      addr      <= '0;
      remaining <= '0;
    end else if (state == IDLE && start_in) begin
      snapshot  <= bulk_read_data_in;
      addr      <= first_address_in;
      remaining <= eff_len;
    end else if (xfer && remaining != '0) begin
      addr      <= (addr == LAST_ADDR) ? '0 : addr + AW'(1);
      remaining <= remaining - (AW+1)'(1);
    end
  end

  assign stream_valid_out = (state == STREAM);
  assign stream_data_out  = stream_valid_out ? beat_data : '0;
  assign stream_last_out  = stream_valid_out && final_beat;
  assign busy_out         = (state != IDLE);
  assign done_out         = (state == DONE);
  assign fsm_state        = state;

endmodule

// File: tb/tb_tensor_core_result_unloader.sv
// Scoreboard bench for tensor_core_result_unloader: stimulus pushes expected beats, a negedge monitor pops them.
// Covers the checksum beat as well when TENSOR_UNLOADER_CHECKSUM_EN is defined.
module tb_tensor_core_result_unloader;

  localparam int N  = 32;
  localparam int DW = 8;

  logic                 clock_in = 1'b0;
  logic                 reset_in;
  logic                 start_in;
  logic [4:0]           first_address_in;
  logic [5:0]           length_in;
  logic signed [DW-1:0] bulk [2][4][4];
  logic signed [DW-1:0] stream_data_out;
  logic                 stream_valid_out;
  logic                 stream_ready_in;
  logic                 stream_last_out;
  logic                 busy_out;
  logic                 done_out;
  logic [1:0]           fsm_state;

  tensor_core_result_unloader #(
    .NUMBER_OF_REGISTERS(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .start_in(start_in),
    .first_address_in(first_address_in),
    .length_in(length_in),
    .bulk_read_data_in(bulk),
    .stream_data_out(stream_data_out),
    .stream_valid_out(stream_valid_out),
    .stream_ready_in(stream_ready_in),
    .stream_last_out(stream_last_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;
  logic [DW:0] exp_q[$];
  logic [DW-1:0] model_mem [N];
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int start_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic apply_mem();
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          bulk[m][r][c] = model_mem[m*16 + r*4 + c];
  endtask

  // Expected beats as seen by the consumer: {last, data}
  task automatic push_expected(input int first, input int len, output int nbeats);
    int eff;
    logic [DW-1:0] sum;
    bit csum_on;
    eff = (len == 0 || len > N) ? N : len;
    sum = '0;
    csum_on = 1'b0;
`ifdef TENSOR_UNLOADER_CHECKSUM_EN
    csum_on = 1'b1;
`endif
    for (int i = 0; i < eff; i++) begin
      logic [DW-1:0] v;
      v = model_mem[(first + i) % N];
      sum = sum + v;
      exp_q.push_back({(i == eff - 1) && !csum_on, v});
    end
    nbeats = eff;
    if (csum_on) begin
      exp_q.push_back({1'b1, sum});
      nbeats = eff + 1;
    end
  endtask

  // driver: called just after a rising edge; returns just after the start edge
  task automatic start_xfer(input int first, input int len, input bit auto_exp, output int nbeats);
    apply_mem();
    first_address_in = 5'(first);
    length_in = 6'(len);
    start_in = 1'b1;
    nbeats = 0;
    if (auto_exp) push_expected(first, len, nbeats);
    @(posedge clock_in); #1;
    start_in = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input bit stall_pat, input int budget, output int done_c);
    done_c = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_out) begin
        done_c = cyc;
        break;
      end
      stream_ready_in = stall_pat ? pat[i % 4] : 1'b1;
      @(posedge clock_in); #1;
    end
    if (done_c < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_out within %0d cycles, required a pulse", budget);
    end else begin
      check("done_state", 32'(fsm_state), 32'd2);
      check("done_valid_low", 32'(stream_valid_out), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clock_in); #1;
      check("done_one_cycle", 32'(done_out), 32'd0);
      check("idle_not_busy", 32'(busy_out), 32'd0);
    end
    stream_ready_in = 1'b1;
  endtask

  // monitor / scoreboard
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge clock_in) begin
    if (reset_in) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!stream_valid_out || stream_data_out !== prev_data || stream_last_out !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%0h last=%0b, required valid=1 data=%0h last=%0b",
                   stream_valid_out, stream_data_out, stream_last_out, prev_data, prev_last);
        end
      end
      if (stream_valid_out && stream_ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%0h last=%0b, required no beat",
                   stream_data_out, stream_last_out);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({stream_last_out, stream_data_out} !== e) begin
            errors++;
            $display("FAIL beat: got last=%0b data=%0h, required last=%0b data=%0h",
                     stream_last_out, stream_data_out, e[DW], e[DW-1:0]);
          end
        end
        beats_seen++;
      end
      prev_stall = stream_valid_out && !stream_ready_in;
      prev_data  = stream_data_out;
      prev_last  = stream_last_out;
    end
  end

  initial begin
    int nb, dc, b0;
    reset_in = 1'b1;
    start_in = 1'b0;
    first_address_in = '0;
    length_in = '0;
    stream_ready_in = 1'b1;
    for (int a = 0; a < N; a++) model_mem[a] = 8'(a + 1);
    apply_mem();
    repeat (3) @(posedge clock_in);
    #1;
    check("rst_valid", 32'(stream_valid_out), 32'd0);
    check("rst_last", 32'(stream_last_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_data", 32'(stream_data_out), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset_in = 1'b0;
    @(posedge clock_in); #1;

    // beats 1..16 back to back, done one cycle after the last beat
    start_xfer(0, 16, 1'b1, nb);
    check("first_cycle_valid", 32'(stream_valid_out), 32'd1);
    check("first_cycle_data", 32'(stream_data_out), 32'd1);
    check("busy_in_stream", 32'(busy_out), 32'd1);
    wait_done(1'b0, 100, dc);
    check("full_throughput_latency", 32'(dc - start_cyc), 32'(nb));

    // wrap-around: elements 30, 31, 0, 1 hold 31, 32, 1, 2
    start_xfer(30, 4, 1'b1, nb);
    wait_done(1'b0, 100, dc);

    // stalls with ready pattern 1,0,0,1
    start_xfer(3, 6, 1'b1, nb);
    wait_done(1'b1, 200, dc);

    // len=0 gives 32 beats; mid-transfer start ignored; bulk changes after start ignored
    for (int a = 0; a < N; a++) model_mem[a] = 8'(a * 7 + 3);
    b0 = beats_seen;
    start_xfer(0, 0, 1'b1, nb);
    @(posedge clock_in); #1;
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          bulk[m][r][c] = 8'sh55;
    first_address_in = 5'd7;
    length_in = 6'd3;
    start_in = 1'b1;
    @(posedge clock_in); #1;
    start_in = 1'b0;
    wait_done(1'b0, 200, dc);
    check("len0_beat_count", 32'(beats_seen - b0), 32'(nb));

    // length beyond the register count clamps to 32
    start_xfer(16, 40, 1'b1, nb);
    wait_done(1'b0, 200, dc);

    // reset after beat 5 of 16 aborts, then a fresh start works
    for (int a = 0; a < N; a++) model_mem[a] = 8'(a + 1);
    b0 = beats_seen;
    start_xfer(0, 16, 1'b1, nb);
    repeat (5) @(posedge clock_in);
    #1;
    check("beats_before_abort", 32'(beats_seen - b0), 32'd5);
    reset_in = 1'b1;
    exp_q.delete();
    #1;
    check("abort_valid", 32'(stream_valid_out), 32'd0);
    check("abort_busy", 32'(busy_out), 32'd0);
    check("abort_done", 32'(done_out), 32'd0);
    check("abort_data", 32'(stream_data_out), 32'd0);
    @(posedge clock_in); #1;
    reset_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock_in); #1;
      check("no_done_after_abort", 32'(done_out), 32'd0);
      check("no_valid_after_abort", 32'(stream_valid_out), 32'd0);
    end
    start_xfer(5, 3, 1'b1, nb);
    wait_done(1'b0, 100, dc);

`ifdef TENSOR_UNLOADER_CHECKSUM_EN
    // 0x7F + 0x02 = 0x81, last moves onto the checksum beat
    model_mem[0] = 8'h7F;
    model_mem[1] = 8'h02;
    exp_q.push_back({1'b0, 8'h7F});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'h81});
    start_xfer(0, 2, 1'b0, nb);
    wait_done(1'b0, 100, dc);
`endif

    repeat (3) @(posedge clock_in);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
